// File: rtl/ifstage_prefetch_pkg.sv
// Shared constants for the prefetching instruction-fetch stage.
// Holds the PC step, the default reset PC and the queue counter sizing rule.
package ifstage_prefetch_pkg;

    localparam int          PC_INCR          = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // The count must represent 0..depth inclusive, hence one bit beyond the pointer.
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifstage_prefetch_fifo.sv
// Prefetch queue: DEPTH entries of {instruction, pc}, synchronous flush.
// Pops on an empty queue and pushes on a full queue are ignored.
module ifstage_prefetch_fifo
    import ifstage_prefetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = countWidth(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             doPush;
    logic             doPop;

    assign doPop   = pop_i & (count_q != '0);
    assign doPush  = push_i & (count_q != CNT_W'(DEPTH));
    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + CNT_W'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush && !flush_i) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ifstage_prefetch.sv
// Instruction-fetch stage: sequential word requests to a 1-cycle memory,
// buffered in a prefetch queue and handed to decode; redirect flushes everything.
module ifstage_prefetch
    import ifstage_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PC_LdEn,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] Redirect_Target,
    output logic              Imem_Req,
    output logic [ADDR_W-1:0] Imem_Addr,
    input  logic [DATA_W-1:0] Imem_Rdata,
    output logic              Instr_Valid,
    input  logic              Instr_Ready,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] Instr_PC
);

    localparam int CNT_W   = countWidth(DEPTH);
    localparam int SUM_W   = CNT_W + 1;
    localparam int ENTRY_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0]  fetchPc_q;
    logic [ADDR_W-1:0]  fetchPc_d;
    logic [ADDR_W-1:0]  inflightPc_q;
    logic [ADDR_W-1:0]  inflightPc_d;
    logic               inflight_q;
    logic               inflight_d;
    logic [CNT_W-1:0]   count;
    logic [SUM_W-1:0]   committed;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;
    logic               unusedTargetLsbs;

    // Queued entries plus the one in flight must leave room, so a response never drops.
    assign committed        = {1'b0, count} + SUM_W'(inflight_q);
    assign Imem_Req         = Reset & PC_LdEn & ~Redirect & (committed < SUM_W'(DEPTH));
    assign Imem_Addr        = fetchPc_q;
    assign push             = inflight_q & ~Redirect;
    assign Instr_Valid      = Reset & (count != '0);
    assign pop              = Instr_Valid & Instr_Ready;
    assign {Instr, Instr_PC} = head;
    assign unusedTargetLsbs = ^Redirect_Target[1:0];

    always_comb begin
        fetchPc_d    = fetchPc_q;
        inflightPc_d = inflightPc_q;
        inflight_d   = 1'b0;
        if (Redirect) begin
            fetchPc_d = {Redirect_Target[ADDR_W-1:2], 2'b00};
        end else if (Imem_Req) begin
            fetchPc_d    = fetchPc_q + ADDR_W'(PC_INCR);
            inflightPc_d = fetchPc_q;
            inflight_d   = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fetchPc_q    <= RESET_PC;
            inflightPc_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            fetchPc_q    <= fetchPc_d;
            inflightPc_q <= inflightPc_d;
            inflight_q   <= inflight_d;
        end
    end

    ifstage_prefetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .flush_i (Redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({Imem_Rdata, inflightPc_q}),
        .rdata_o (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_ifstage_prefetch.sv
// Bench for ifstage_prefetch: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the fetch stage.
module tb_ifstage_prefetch;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        ldEn = 1'b0;
    logic        redir = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] target = '0;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata = '0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] instrPc;

    logic        rstN2 = 1'b0;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] rdata2 = '0;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] instrPc2;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: fetch PC, one in-flight PC and a queue of buffered PCs.
    logic [31:0] mFetch = '0;
    logic [31:0] mInflightPc = '0;
    bit          mInflight = 1'b0;
    logic [31:0] mQueue[$];

    always #5 clk = ~clk;

    // Memory model: data is the address XOR a pattern, one cycle later.
    always @(posedge clk) begin
        rdata  <= addr ^ XOR_PAT;
        rdata2 <= addr2 ^ XOR_PAT;
    end

    ifstage_prefetch #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)
    ) dut (
        .Clk(clk), .Reset(rstN), .PC_LdEn(ldEn), .Redirect(redir),
        .Redirect_Target(target), .Imem_Req(req), .Imem_Addr(addr),
        .Imem_Rdata(rdata), .Instr_Valid(valid), .Instr_Ready(ready),
        .Instr(instr), .Instr_PC(instrPc)
    );

    ifstage_prefetch #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)
    ) dutWrap (
        .Clk(clk), .Reset(rstN2), .PC_LdEn(1'b1), .Redirect(1'b0),
        .Redirect_Target(32'h0), .Imem_Req(req2), .Imem_Addr(addr2),
        .Imem_Rdata(rdata2), .Instr_Valid(valid2), .Instr_Ready(1'b1),
        .Instr(instr2), .Instr_PC(instrPc2)
    );

    function automatic bit mReq();
        return rstN && ldEn && !redir && ((mQueue.size() + int'(mInflight)) < DEPTH);
    endfunction

    function automatic bit mValid();
        return rstN && (mQueue.size() != 0);
    endfunction

    task automatic drive(input bit r, input bit l, input bit d, input bit y, input logic [31:0] t);
        rstN   = r;
        ldEn   = l;
        redir  = d;
        ready  = y;
        target = t;
    endtask

    // Advance one clock edge and step the model with the inputs seen at that edge.
    task automatic tick();
        bit issue;
        @(posedge clk);
        issue = mReq();
        if (!rstN) begin
            mQueue.delete();
            mInflight = 1'b0;
            mFetch    = 32'h0;
        end else if (redir) begin
            mQueue.delete();
            mInflight = 1'b0;
            mFetch    = target & ~32'h3;
        end else begin
            if (mValid() && ready) void'(mQueue.pop_front());
            if (mInflight) mQueue.push_back(mInflightPc);
            mInflight = issue;
            if (issue) begin
                mInflightPc = mFetch;
                mFetch      = mFetch + 32'd4;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 1, 0, 1, 32'h0);
        tick();
        tick();
        @(negedge clk);
        nCompared++;
        if (req !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_req: got %b want 0", req);
        end
        nCompared++;
        if (valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_valid: got %b want 0", valid);
        end
        nCompared++;
        if (addr !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_addr: got %h want 00000000", addr);
        end
    endtask

    task automatic test_stream();
        int firstReq = -1;
        int firstValid = -1;
        int nGot = 0;
        drive(0, 1, 0, 1, 32'h0);
        tick();
        drive(1, 1, 0, 1, 32'h0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req && firstReq < 0) firstReq = c;
            nCompared++;
            if (req !== 1'b1 || addr !== 32'(4 * c)) begin
                nMismatched++;
                $display("[TB] FAIL stream_addr c%0d: got req=%b addr=%h want req=1 addr=%h", c, req, addr, 32'(4 * c));
            end
            if (valid === 1'b1) begin
                if (firstValid < 0) firstValid = c;
                nCompared++;
                if (instrPc !== 32'(4 * nGot) || instr !== (32'(4 * nGot) ^ XOR_PAT)) begin
                    nMismatched++;
                    $display("[TB] FAIL stream_instr: got pc=%h instr=%h want pc=%h instr=%h",
                             instrPc, instr, 32'(4 * nGot), 32'(4 * nGot) ^ XOR_PAT);
                end
                nGot++;
            end
            tick();
        end
        nCompared++;
        if (firstReq != 0 || firstValid != 2) begin
            nMismatched++;
            $display("[TB] FAIL stream_latency: got req@%0d valid@%0d want req@0 valid@2", firstReq, firstValid);
        end
        nCompared++;
        if (nGot != 10) begin
            nMismatched++;
            $display("[TB] FAIL stream_count: got %0d want 10", nGot);
        end
    endtask

    task automatic test_backpressure();
        int nReq = 0;
        int nGot = 0;
        drive(0, 1, 0, 0, 32'h0);
        tick();
        drive(1, 1, 0, 0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req === 1'b1) nReq++;
            nCompared++;
            if (c >= 4 && req !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL bp_req_low c%0d: got %b want 0", c, req);
            end
            tick();
        end
        nCompared++;
        if (nReq != 4 || valid !== 1'b1 || instrPc !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL bp_fill: got reqs=%0d valid=%b pc=%h want reqs=4 valid=1 pc=0", nReq, valid, instrPc);
        end
        drive(1, 1, 0, 1, 32'h0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                nCompared++;
                if (instrPc !== 32'(4 * nGot)) begin
                    nMismatched++;
                    $display("[TB] FAIL bp_drain: got pc=%h want %h", instrPc, 32'(4 * nGot));
                end
                nGot++;
            end
            tick();
        end
        nCompared++;
        if (nGot < 5) begin
            nMismatched++;
            $display("[TB] FAIL bp_drain_count: got %0d want >=5", nGot);
        end
    endtask

    task automatic test_redirect();
        int nGot = 0;
        drive(0, 1, 0, 0, 32'h0);
        tick();
        drive(1, 1, 0, 0, 32'h0);
        tick();
        tick();
        tick();
        drive(1, 1, 1, 0, 32'h0000_0043);
        @(negedge clk);
        nCompared++;
        if (valid !== 1'b1 || req !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL redir_cycle: got valid=%b req=%b want valid=1 req=0", valid, req);
        end
        tick();
        drive(1, 1, 0, 1, 32'h0);
        @(negedge clk);
        nCompared++;
        if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h40) begin
            nMismatched++;
            $display("[TB] FAIL redir_flush: got valid=%b req=%b addr=%h want valid=0 req=1 addr=00000040", valid, req, addr);
        end
        for (int c = 0; c < 8 && nGot < 2; c++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                nCompared++;
                if (instrPc !== (32'h40 + 32'(4 * nGot))) begin
                    nMismatched++;
                    $display("[TB] FAIL redir_target: got pc=%h want %h", instrPc, 32'h40 + 32'(4 * nGot));
                end
                nGot++;
            end
            tick();
        end
        nCompared++;
        if (nGot != 2) begin
            nMismatched++;
            $display("[TB] FAIL redir_timeout: got %0d instrs want 2", nGot);
        end
    endtask

    task automatic test_ldEn();
        int nGot = 0;
        drive(0, 1, 0, 0, 32'h0);
        tick();
        drive(1, 1, 0, 0, 32'h0);
        tick();
        tick();
        drive(1, 0, 0, 0, 32'h0);
        tick();
        tick();
        drive(1, 0, 0, 1, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nCompared++;
            if (req !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL ld_frozen: got req=%b want 0", req);
            end
            if (valid === 1'b1) begin
                nCompared++;
                if (instrPc !== 32'(4 * nGot)) begin
                    nMismatched++;
                    $display("[TB] FAIL ld_drain: got pc=%h want %h", instrPc, 32'(4 * nGot));
                end
                nGot++;
            end
            tick();
        end
        nCompared++;
        if (nGot != 2 || valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL ld_drained: got %0d instrs valid=%b want 2 and 0", nGot, valid);
        end
        drive(1, 1, 0, 1, 32'h0);
        @(negedge clk);
        nCompared++;
        if (req !== 1'b1 || addr !== 32'h8) begin
            nMismatched++;
            $display("[TB] FAIL ld_resume: got req=%b addr=%h want req=1 addr=00000008", req, addr);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 0, 32'h0);
        for (int c = 0; c < 8; c++) tick();
        drive(0, 1, 0, 1, 32'h0);
        @(negedge clk);
        nCompared++;
        if (req !== 1'b0 || valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_hold: got req=%b valid=%b want 0 0", req, valid);
        end
        tick();
        drive(1, 1, 0, 1, 32'h0);
        @(negedge clk);
        nCompared++;
        if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_restart: got valid=%b req=%b addr=%h want 0 1 00000000", valid, req, addr);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, $urandom);
            @(negedge clk);
            nCompared++;
            if (req !== mReq() || addr !== mFetch || valid !== mValid()) begin
                nMismatched++;
                $display("[TB] FAIL rand_ctrl c%0d: got req=%b addr=%h valid=%b want req=%b addr=%h valid=%b",
                         c, req, addr, valid, mReq(), mFetch, mValid());
            end else if (mValid()) begin
                nCompared++;
                if (instrPc !== mQueue[0] || instr !== (mQueue[0] ^ XOR_PAT)) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_head c%0d: got pc=%h instr=%h want pc=%h instr=%h",
                             c, instrPc, instr, mQueue[0], mQueue[0] ^ XOR_PAT);
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] expPc[3];
        int nGot = 0;
        expPc[0] = 32'hFFFF_FFF8;
        expPc[1] = 32'hFFFF_FFFC;
        expPc[2] = 32'h0000_0000;
        rstN2 = 1'b0;
        tick();
        rstN2 = 1'b1;
        for (int c = 0; c < 10 && nGot < 3; c++) begin
            @(negedge clk);
            if (valid2 === 1'b1) begin
                nCompared++;
                if (instrPc2 !== expPc[nGot] || instr2 !== (expPc[nGot] ^ XOR_PAT)) begin
                    nMismatched++;
                    $display("[TB] FAIL wrap_pc: got pc=%h instr=%h want pc=%h instr=%h",
                             instrPc2, instr2, expPc[nGot], expPc[nGot] ^ XOR_PAT);
                end
                nGot++;
            end
            tick();
        end
        nCompared++;
        if (nGot != 3) begin
            nMismatched++;
            $display("[TB] FAIL wrap_timeout: got %0d instrs want 3", nGot);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_ldEn();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
